// File: rtl/tft_spi_stream.sv
// Buffered SPI mode-0 transmitter for the TFT panel.
// A valid/ready stream fills a FIFO of {dc, wide, word} entries; the engine
// shifts them out MSB first and keeps CS low across back-to-back words.
// Pin outputs are registered from the engine state, so every pin lags the
// engine by one clk; phase lengths are unaffected by that uniform lag.
module tft_spi_stream #(
  parameter int unsigned CLK_DIV    = 1,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CS_GAP     = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [15:0]                   in_word,
  input  logic                          in_dc,
  input  logic                          in_wide,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tft_clk,
  output logic                          tft_mosi,
  output logic                          tft_cs,
  output logic                          tft_dc,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] LevelFull = LW'(FIFO_DEPTH);
  localparam logic [15:0]   DivLast   = 16'(CLK_DIV - 1);
  localparam logic [15:0]   GapLast   = 16'(CS_GAP - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StHigh,
    StLow,
    StHold,
    StGap
  } state_e;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [17:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]  level_q, level_d;
  logic           push, pop, fifo_empty;
  logic [17:0]    head;

  // Held low while in reset so nothing is accepted on the reset edge.
  assign in_ready   = ~rst & (level_q != LevelFull);
  assign push       = in_valid & in_ready;
  assign fifo_empty = (level_q == '0);
  assign head       = mem_q[rd_ptr_q];
  assign fifo_level = level_q;

  // FIFO pointer and level next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    level_d = level_q + LW'(push) - LW'(pop);
  end

  // FIFO storage write; contents need no reset, the level guards them
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_dc, in_wide, in_word};
  end

  // FIFO pointer and level registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Shift engine
  // ---------------------------------------------------------------------------
  state_e        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [15:0]   shift_q, shift_d;
  logic          dc_q, dc_d;
  logic          phase_done;

  // GAP counts CS_GAP cycles, every other phase counts CLK_DIV cycles.
  assign phase_done = (cnt_q == ((state_q == StGap) ? GapLast : DivLast));
  assign busy       = ~fifo_empty | (state_q != StIdle);

  // Engine next-state, phase counter, bit counter and FIFO pop
  always_comb begin
    state_d = state_q;
    cnt_d   = phase_done ? 16'd0 : cnt_q + 16'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    dc_d    = dc_q;
    pop     = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = StSetup;
        end
      end
      StSetup: if (phase_done) state_d = StHigh;
      StHigh: begin
        if (phase_done) begin
          if (bit_q != 4'd0) begin
            state_d = StLow;
            bit_d   = bit_q - 4'd1;
            shift_d = {shift_q[14:0], 1'b0};
          end else if (!fifo_empty) begin
            // Next word rides straight in; this LOW phase is its setup.
            pop     = 1'b1;
            state_d = StLow;
          end else begin
            state_d = StHold;
          end
        end
      end
      StLow:  if (phase_done) state_d = StHigh;
      StHold: if (phase_done) state_d = StGap;
      StGap: begin
        if (phase_done) begin
          // A word already waiting starts immediately, so CS is high for
          // exactly CS_GAP cycles.
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = StSetup;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Narrow words are left-aligned so the MSB is always shift[15].
    if (pop) begin
      dc_d    = head[17];
      bit_d   = head[16] ? 4'd15 : 4'd7;
      shift_d = head[16] ? head[15:0] : {head[7:0], 8'h00};
    end
  end

  // Engine registers; shift resets to ones so MOSI idles high after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '1;
      dc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      dc_q    <= dc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Pin registers
  // ---------------------------------------------------------------------------
  logic sck_q, sck_d;
  logic cs_q, cs_d;
  logic mosi_q, mosi_d;
  logic dcp_q, dcp_d;

  // Pin values decoded from the current engine state
  always_comb begin
    sck_d  = (state_q == StHigh);
    cs_d   = ~(state_q inside {StSetup, StHigh, StLow, StHold});
    mosi_d = shift_q[15];
    dcp_d  = dc_q;
  end

  // Pin output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_q  <= 1'b0;
      cs_q   <= 1'b1;
      mosi_q <= 1'b1;
      dcp_q  <= 1'b0;
    end else begin
      sck_q  <= sck_d;
      cs_q   <= cs_d;
      mosi_q <= mosi_d;
      dcp_q  <= dcp_d;
    end
  end

  assign tft_clk  = sck_q;
  assign tft_cs   = cs_q;
  assign tft_mosi = mosi_q;
  assign tft_dc   = dcp_q;

endmodule
